// File: rtl/hl_sequencer_pkg.sv
// Shared state encoding and width helper for the hidden-layer sequencer.
package hl_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StFeed = 3'd1,
    StWait = 3'd2,
    StDone = 3'd3,
    StErr  = 3'd4
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hl_result_capture.sv
// Per-neuron result register with a capture mask; the first valid per neuron wins.
module hl_result_capture
  import hl_sequencer_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned WIDTH       = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         enable_i,
  input  logic [NUM_OUTPUTS-1:0]       valids_i,
  input  logic [NUM_OUTPUTS*WIDTH-1:0] values_i,
  output logic [NUM_OUTPUTS-1:0]       mask_o,
  output logic [NUM_OUTPUTS*WIDTH-1:0] result_o
);

  logic [NUM_OUTPUTS-1:0]       mask_q, mask_d;
  logic [NUM_OUTPUTS*WIDTH-1:0] result_q, result_d;

  // Mask and result state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q   <= '0;
      result_q <= '0;
    end else begin
      mask_q   <= mask_d;
      result_q <= result_d;
    end
  end

  // Capture lanes whose valid fires while not yet captured.
  always_comb begin
    mask_d   = mask_q;
    result_d = result_q;
    if (clear_i) begin
      mask_d   = '0;
      result_d = '0;
    end else if (enable_i) begin
      for (int n = 0; n < NUM_OUTPUTS; n++) begin
        if (valids_i[n] && !mask_q[n]) begin
          result_d[n*WIDTH +: WIDTH] = values_i[n*WIDTH +: WIDTH];
          mask_d[n]                  = 1'b1;
        end
      end
    end
  end

  assign mask_o   = mask_q;
  assign result_o = result_q;

endmodule

// File: rtl/hl_sequencer.sv
// Runs one pass through a fully-connected layer: stream inputs, gather outputs, hand back.
module hl_sequencer
  import hl_sequencer_pkg::*;
#(
  parameter int unsigned NUM_INPUTS     = 4,
  parameter int unsigned NUM_OUTPUTS    = 4,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [NUM_INPUTS*WIDTH-1:0]  vector_in_i,
  output logic                         busy_o,
  input  logic                         layer_ready_i,
  output logic [WIDTH-1:0]             layer_value_o,
  output logic                         layer_valid_o,
  input  logic [NUM_OUTPUTS*WIDTH-1:0] layer_values_i,
  input  logic [NUM_OUTPUTS-1:0]       layer_valids_i,
  input  logic                         layer_overflow_i,
  output logic [NUM_OUTPUTS*WIDTH-1:0] result_o,
  output logic                         result_valid_o,
  input  logic                         result_ack_i,
  output logic                         overflow_o,
  output logic                         error_o
);

  localparam int unsigned IdxW = (clog2(NUM_INPUTS) < 1) ? 1 : clog2(NUM_INPUTS);
  localparam int unsigned WdW  = clog2(TIMEOUT_CYCLES);

  state_e                      state_q, state_d;
  logic [NUM_INPUTS*WIDTH-1:0] vec_q, vec_d;
  logic [IdxW-1:0]             idx_q, idx_d, idx_next;
  logic                        valid_q, valid_d;
  logic [WIDTH-1:0]            value_q, value_d;
  logic [WdW-1:0]              wd_q, wd_d;
  logic                        ovf_q, ovf_d;
  logic                        cap_clear, cap_en, mask_full, beat;
  logic [NUM_OUTPUTS-1:0]      mask;
  logic [WIDTH-1:0]            elems [NUM_INPUTS];

  hl_result_capture #(
    .NUM_OUTPUTS(NUM_OUTPUTS),
    .WIDTH      (WIDTH)
  ) u_capture (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (cap_clear),
    .enable_i(cap_en),
    .valids_i(layer_valids_i),
    .values_i(layer_values_i),
    .mask_o  (mask),
    .result_o(result_o)
  );

  // Unpack the latched vector into addressable elements.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) elems[i] = vec_q[i*WIDTH +: WIDTH];
  end

  // Control state, feeder registers and watchdog.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      vec_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      value_q <= '0;
      wd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      value_q <= value_d;
      wd_q    <= wd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic; full mask (including this cycle's captures) beats the timeout.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    value_d   = value_q;
    wd_d      = wd_q;
    ovf_d     = ovf_q;
    cap_clear = 1'b0;
    cap_en    = 1'b0;
    idx_next  = idx_q + IdxW'(1);
    mask_full = &(mask | layer_valids_i);
    beat      = valid_q & layer_ready_i;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          vec_d     = vector_in_i;
          idx_d     = '0;
          valid_d   = 1'b1;
          value_d   = vector_in_i[WIDTH-1:0];
          ovf_d     = 1'b0;
          cap_clear = 1'b1;
          state_d   = StFeed;
        end
      end
      StFeed: begin
        cap_en = 1'b1;
        if (layer_overflow_i) ovf_d = 1'b1;
        if (beat) begin
          if (idx_q == IdxW'(NUM_INPUTS - 1)) begin
            valid_d = 1'b0;
            wd_d    = '0;
            state_d = StWait;
          end else begin
            idx_d   = idx_next;
            value_d = elems[idx_next];
          end
        end
      end
      StWait: begin
        cap_en = 1'b1;
        if (layer_overflow_i) ovf_d = 1'b1;
        if (mask_full) begin
          state_d = StDone;
        end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StErr;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StDone: begin
        if (result_ack_i) state_d = StIdle;
      end
      StErr: begin
        if (result_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o         = (state_q != StIdle);
  assign result_valid_o = (state_q == StDone);
  assign error_o        = (state_q == StErr);
  assign layer_valid_o  = valid_q;
  assign layer_value_o  = value_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_hl_sequencer.sv
// Directed self-checking bench for hl_sequencer (4 inputs, 4 outputs, 8-bit, timeout 16).
module tb_hl_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] vector;
  logic        busy;
  logic        ready;
  logic [7:0]  value;
  logic        valid;
  logic [31:0] values;
  logic [3:0]  valids;
  logic        ovf_in;
  logic [31:0] result;
  logic        result_valid;
  logic        ack;
  logic        overflow;
  logic        error;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  hl_sequencer #(
    .NUM_INPUTS    (4),
    .NUM_OUTPUTS   (4),
    .WIDTH         (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .vector_in_i     (vector),
    .busy_o          (busy),
    .layer_ready_i   (ready),
    .layer_value_o   (value),
    .layer_valid_o   (valid),
    .layer_values_i  (values),
    .layer_valids_i  (valids),
    .layer_overflow_i(ovf_in),
    .result_o        (result),
    .result_valid_o  (result_valid),
    .result_ack_i    (ack),
    .overflow_o      (overflow),
    .error_o         (error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({busy, valid, value, result, result_valid, overflow, error} !== 45'd0)
      $display("FAIL reset_outputs: got %h, expected 0",
               {busy, valid, value, result, result_valid, overflow, error});
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    vector = 32'h04030201; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({valid, value} !== {1'b1, 8'(i + 1)})
        $display("FAIL nom_beat%0d: got %h, expected %h", i, {valid, value}, {1'b1, 8'(i + 1)});
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({valid, busy, result_valid} !== 3'b010)
      $display("FAIL nom_wait: got %b, expected 010", {valid, busy, result_valid});
    else pass_cnt++;
    for (int i = 0; i < 4; i++) step();
    values = 32'h40302010; valids = 4'hf;
    step(); valids = 4'h0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({result_valid, result} !== {1'b1, 32'h40302010})
        $display("FAIL nom_done%0d: got %h, expected %h", i, {result_valid, result},
                 {1'b1, 32'h40302010});
      else pass_cnt++;
      step();
    end
    ack = 1'b1; step(); ack = 1'b0;
    total_cnt++;
    if ({busy, result_valid, result} !== {2'b00, 32'h40302010})
      $display("FAIL nom_ack: got %h, expected %h", {busy, result_valid, result},
               {2'b00, 32'h40302010});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int         pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [7:0] exp_bp [4] = '{8'h05, 8'h80, 8'h7f, 8'hfe};
    logic [7:0] got [8];
    logic [7:0] prev;
    int         n = 0;
    vector = 32'hfe7f8005; ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      ready = pat[k][0];
      if (valid && ready && n < 8) begin
        got[n] = value;
        n++;
      end
      prev = value;
      step();
      if (pat[k] == 0) begin
        total_cnt++;
        if (value !== prev) $display("FAIL bp_hold%0d: got %h, expected %h", k, value, prev);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (n !== 4 || valid !== 1'b0)
      $display("FAIL bp_count: got %0d beats valid=%b, expected 4 beats valid=0", n, valid);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got[i] !== exp_bp[i]) $display("FAIL bp_elem%0d: got %h, expected %h", i, got[i],
                                         exp_bp[i]);
      else pass_cnt++;
    end
    ready = 1'b1; values = 32'h0; valids = 4'hf;
    step(); valids = 4'h0; ack = 1'b1;
    step(); ack = 1'b0;
  endtask

  task automatic test_staggered();
    logic [3:0]  vm [5] = '{4'h1, 4'h2, 4'h4, 4'h4, 4'h8};
    logic [31:0] vv [5] = '{32'h00000011, 32'h00002200, 32'h00330000, 32'h00990000,
                            32'h44000000};
    vector = 32'h01010101; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int j = 0; j < 5; j++) begin
      valids = vm[j]; values = vv[j];
      step(); valids = 4'h0;
      if (j < 4) begin
        total_cnt++;
        if (result_valid !== 1'b0) $display("FAIL stag_early%0d: got 1, expected 0", j);
        else pass_cnt++;
      end
      if (j == 3) begin
        total_cnt++;
        if (result !== 32'h00332211)
          $display("FAIL stag_partial: got %h, expected 00332211", result);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({result_valid, result} !== {1'b1, 32'h44332211})
      $display("FAIL stag_done: got %h, expected %h", {result_valid, result},
               {1'b1, 32'h44332211});
    else pass_cnt++;
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic test_watchdog();
    vector = 32'h0; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    values = 32'haabbccdd;
    for (int i = 0; i < 16; i++) begin
      valids = (i < 3) ? 4'(1 << i) : 4'h0;
      step();
      if (i == 14) begin
        total_cnt++;
        if ({error, busy} !== 2'b01) $display("FAIL wd_early: got %b, expected 01", {error, busy});
        else pass_cnt++;
      end
    end
    valids = 4'h0;
    total_cnt++;
    if ({error, result_valid, result} !== {2'b10, 32'h00bbccdd})
      $display("FAIL wd_expire: got %h, expected %h", {error, result_valid, result},
               {2'b10, 32'h00bbccdd});
    else pass_cnt++;
    ack = 1'b1; step(); ack = 1'b0;
    total_cnt++;
    if ({error, busy} !== 2'b00) $display("FAIL wd_ack: got %b, expected 00", {error, busy});
    else pass_cnt++;
  endtask

  task automatic test_overflow_busy();
    vector = 32'h0d0c0b0a; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    ovf_in = 1'b1; start = 1'b1; vector = 32'h55555555;
    step(); ovf_in = 1'b0; start = 1'b0;
    total_cnt++;
    if ({overflow, value} !== {1'b1, 8'h0b})
      $display("FAIL ovf_set: got %h, expected %h", {overflow, value}, {1'b1, 8'h0b});
    else pass_cnt++;
    for (int i = 0; i < 3; i++) step();
    values = 32'h01020304; valids = 4'hf;
    step(); valids = 4'h0;
    total_cnt++;
    if ({result_valid, overflow} !== 2'b11)
      $display("FAIL ovf_done: got %b, expected 11", {result_valid, overflow});
    else pass_cnt++;
    ack = 1'b1; step(); ack = 1'b0;
    total_cnt++;
    if ({busy, overflow} !== 2'b01)
      $display("FAIL ovf_idle: got %b, expected 01", {busy, overflow});
    else pass_cnt++;
    vector = 32'h0; start = 1'b1;
    step(); start = 1'b0;
    total_cnt++;
    if ({busy, overflow} !== 2'b10)
      $display("FAIL ovf_clear: got %b, expected 10", {busy, overflow});
    else pass_cnt++;
    for (int i = 0; i < 4; i++) step();
    valids = 4'hf;
    step(); valids = 4'h0; ack = 1'b1;
    step(); ack = 1'b0;
  endtask

  task automatic test_reset_mid_feed();
    vector = 32'h24232221; ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    ovf_in = 1'b1; valids = 4'h1; values = 32'h000000ee;
    step(); ovf_in = 1'b0; valids = 4'h0;
    step();
    total_cnt++;
    if ({overflow, value, result} !== {1'b1, 8'h23, 32'h000000ee})
      $display("FAIL rst_pre: got %h, expected %h", {overflow, value, result},
               {1'b1, 8'h23, 32'h000000ee});
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, valid, value, result, result_valid, overflow, error} !== 45'd0)
      $display("FAIL rst_async: got %h, expected 0",
               {busy, valid, value, result, result_valid, overflow, error});
    else pass_cnt++;
    step(); rst = 1'b0;
    vector = 32'h34333231; start = 1'b1;
    step(); start = 1'b0;
    total_cnt++;
    if ({valid, value} !== {1'b1, 8'h31})
      $display("FAIL rst_restart0: got %h, expected %h", {valid, value}, {1'b1, 8'h31});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({valid, value} !== {1'b1, 8'h32})
      $display("FAIL rst_restart1: got %h, expected %h", {valid, value}, {1'b1, 8'h32});
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vector = '0; ready = 1'b0;
    values = '0; valids = '0; ovf_in = 1'b0; ack = 1'b0;
    #12;
    test_reset();
    step();
    rst = 1'b0;
    step();
    test_nominal();
    test_backpressure();
    test_staggered();
    test_watchdog();
    test_overflow_busy();
    test_reset_mid_feed();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hl_sequencer.md
Name: hl_sequencer

Overview:
- Controller that runs one inference pass through a fully-connected hidden layer.
- Latches an input vector from upstream on START. Streams it one element per beat into the layer's serial-value input, using that input's READY/VALID handshake.
- Captures each neuron's output as its per-neuron valid fires, then presents the full result vector upstream until acknowledged.
- Sits between the network-level controller and the layer instance. Also provides a watchdog and sticky overflow reporting.

Parameters:
- NUM_INPUTS, 4: elements per input vector, i.e. beats streamed into the layer per pass.
- NUM_OUTPUTS, 4: neurons in the layer, i.e. elements in the result vector.
- WIDTH, 8: signed fixed-point element width.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in WAIT before error; must be ≥ 2.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous assert, active-high
- START  in  1  single-cycle request to begin a pass; honoured only in IDLE
- VECTOR_IN  in  NUM_INPUTS*WIDTH  input vector, element i at [i*WIDTH +: WIDTH]; sampled on the accepted START
- BUSY  out  1  high in every state except IDLE
- LAYER_READY  in  1  layer can accept a value this cycle
- LAYER_VALUE  out  WIDTH  current streamed element
- LAYER_VALID  out  1  LAYER_VALUE is valid
- LAYER_VALUES  in  NUM_OUTPUTS*WIDTH  neuron outputs from the layer
- LAYER_VALIDS  in  NUM_OUTPUTS  per-neuron output valid pulses
- LAYER_OVERFLOW  in  1  OR of neuron overflow flags
- RESULT  out  NUM_OUTPUTS*WIDTH  captured output vector
- RESULT_VALID  out  1  RESULT is complete and held stable
- RESULT_ACK  in  1  upstream consumed RESULT or the error
- OVERFLOW  out  1  sticky overflow seen during the current pass
- ERROR  out  1  watchdog expired

Behaviour:
- Reset values: all outputs 0; state IDLE; capture mask, counters, vector register and RESULT register 0.
- States: IDLE, FEED, WAIT, DONE, ERR.
- IDLE:
  - START=1 latches VECTOR_IN, clears OVERFLOW, capture mask and RESULT, sets index=0, goes to FEED.
  - START is ignored in every other state.
- FEED:
  - LAYER_VALID=1 and LAYER_VALUE=element[index], both registered.
  - A beat transfers when LAYER_VALID & LAYER_READY; index then increments.
  - On the transfer with index=NUM_INPUTS-1, LAYER_VALID drops next cycle and the state goes to WAIT.
  - LAYER_VALUE holds while READY is low.
  - With READY held high, NUM_INPUTS consecutive beats complete in NUM_INPUTS cycles.
- Capture, active in FEED and WAIT:
  - For each neuron n with LAYER_VALIDS[n]=1 and mask[n]=0: RESULT[n] <= LAYER_VALUES[n], mask[n] <= 1.
  - A repeated valid for an already-captured neuron is ignored; the first capture wins.
- WAIT:
  - Watchdog counts from 0, incrementing each WAIT cycle.
  - When the mask becomes all ones (including capture that cycle): go to DONE; RESULT_VALID=1 from the next cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 without a full mask: go to ERR.
  - Full mask takes precedence over timeout in the same cycle.
- DONE: RESULT_VALID=1 and RESULT stable until RESULT_ACK=1; then IDLE next cycle with RESULT_VALID=0. RESULT retains its value in IDLE.
- ERR: ERROR=1 until RESULT_ACK=1; then IDLE, ERROR cleared. RESULT_VALID stays 0.
- OVERFLOW:
  - Set by LAYER_OVERFLOW=1 in FEED or WAIT. Held through DONE/ERR.
  - Cleared only by an accepted START or by reset.
- BUSY = (state != IDLE).
- Reset mid-pass: everything returns to reset values immediately. The layer itself is reset by the same system reset.
- Widths: index is clog2(NUM_INPUTS) bits, minimum 1; the watchdog counter is clog2(TIMEOUT_CYCLES) bits. No arithmetic on data; values pass through unchanged and signed.

Decomposition:
- Shared package: state encoding localparams (IDLE=0, FEED=1, WAIT=2, DONE=3, ERR=4) and a clog2 helper function.
- One natural sub-module: hl_result_capture, holding the per-neuron mask and RESULT register with first-valid-wins logic; ports clear, enable, valids, values, mask, result.
- FSM, feeder and watchdog stay in the top.

Test Plan:
- Nominal pass, NUM_INPUTS=4, NUM_OUTPUTS=4:
  - Stimulus: READY always 1; START with vector {4,3,2,1}; layer model asserts all VALIDS 5 cycles after the last beat with values {0x10,0x20,0x30,0x40}.
  - Required: LAYER_VALUE sequence 1,2,3,4 on 4 consecutive cycles; RESULT={0x40,0x30,0x20,0x10}; RESULT_VALID held until ACK; BUSY falls the cycle after ACK.
- Backpressure: READY toggles 1,0,0,1,1,0,1 -> exactly 4 transfers, no element repeated or skipped; LAYER_VALUE stable while READY=0.
- Staggered valids: neurons 0..3 valid on separate cycles, neuron 2 pulses twice with different values -> first value captured for neuron 2; DONE entered only after neuron 3.
- Watchdog, TIMEOUT_CYCLES=16: neuron 3 never valid -> ERROR=1 exactly 16 cycles after entering WAIT, RESULT_VALID=0; ACK -> IDLE, ERROR=0.
- Overflow and START while busy: LAYER_OVERFLOW pulses once in FEED -> OVERFLOW=1 through DONE. START during FEED is ignored. A new START in IDLE clears OVERFLOW.
- Reset mid-FEED: assert RST after 2 beats -> all outputs 0 asynchronously. A following START streams from element 0.
